// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the instruction-queue entry type for the
// instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam int          INST_W           = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // One buffered instruction together with the address it was fetched from
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } iq_entry_t;

endpackage

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: small circular FIFO of fetched instructions with a
// synchronous clear used by redirects. DEPTH must be a power of two so the
// read/write pointers wrap naturally.
module fetch_inst_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  iq_entry_t     push_data,
  input  logic          pop,
  output iq_entry_t     head,
  output logic [CW-1:0] count
);

  iq_entry_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the queue in one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only meaningful while count covers them
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: instruction-fetch front end. Issues sequential PCs to the
// cache/AXI wrapper with a bounded number of outstanding requests, accepts
// only responses whose pc_req matches the expected PC, and buffers them for
// the ID stage. Redirects restart both PCs and clear the queue; stale
// responses still drain and are dropped by the tag compare.
// Optional build macro: FETCH_IQ_BYPASS_EN presents a matching response
// combinationally to ID when the queue is empty.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          IQ_DEPTH        = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [31:0]       PC,
  output logic              Inst_Req_Valid,
  input  logic              Inst_Req_Ack,
  input  logic [INST_W-1:0] instruction,
  input  logic [31:0]       pc_req,
  input  logic              Inst_Valid,
  output logic              Inst_Ack,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  output logic [INST_W-1:0] id_inst,
  output logic [31:0]       id_pc,
  input  logic              id_ready
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(IQ_DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   expect_pc;
  logic [OW-1:0] outstanding;
  logic [CW-1:0] iq_count;
  logic [31:0]   credit_used;
  logic          req_fire;
  logic          accept;
  logic          bypass_take;
  logic          q_push;
  logic          q_pop;
  iq_entry_t     resp_entry;
  iq_entry_t     iq_head;

  // Credit rule: every issued request has a guaranteed queue slot waiting
  assign credit_used    = 32'(outstanding) + 32'(iq_count);
  assign Inst_Req_Valid = ~reset & (32'(outstanding) < 32'(MAX_OUTSTANDING))
                                 & (credit_used < 32'(IQ_DEPTH));
  assign PC             = fetch_pc;
  assign Inst_Ack       = ~reset;

  assign req_fire   = Inst_Req_Valid & Inst_Req_Ack;
  assign accept     = Inst_Valid & (pc_req == expect_pc) & ~redirect_valid;
  assign resp_entry = '{inst: instruction, pc: pc_req};

`ifdef FETCH_IQ_BYPASS_EN
  assign bypass_take = accept & (iq_count == '0);
`else
  assign bypass_take = 1'b0;
`endif

  assign id_valid = (iq_count != '0) | bypass_take;
  assign q_pop    = (iq_count != '0) & id_ready;
  assign q_push   = accept & ~(bypass_take & id_ready);

  // ID-side head: queue head when buffered, bypassed response otherwise, zero when idle
  always_comb begin
    id_inst = '0;
    id_pc   = '0;
    if (iq_count != '0) begin
      id_inst = iq_head.inst;
      id_pc   = iq_head.pc;
    end else if (bypass_take) begin
      id_inst = resp_entry.inst;
      id_pc   = resp_entry.pc;
    end
  end

  // In-flight request counter; keeps counting across redirects so stale responses drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({req_fire, Inst_Valid})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Fetch and expected PCs; a redirect overrides both sequential advances
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      expect_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc  <= redirect_pc;
      expect_pc <= redirect_pc;
    end else begin
      if (req_fire) fetch_pc  <= fetch_pc + PC_STEP;
      if (accept)   expect_pc <= expect_pc + PC_STEP;
    end
  end

  fetch_inst_queue #(
    .DEPTH(IQ_DEPTH)
  ) u_iq (
    .clk      (clk),
    .reset    (reset),
    .clear    (redirect_valid),
    .push     (q_push),
    .push_data(resp_entry),
    .pop      (q_pop),
    .head     (iq_head),
    .count    (iq_count)
  );

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: drives fetch_pc_gen with a wrapper model that acks
// requests immediately and answers one cycle later, in order. Accepted
// responses are pushed to a scoreboard and compared as ID pops them.
module tb_fetch_pc_gen;
  import fetch_pkg::*;

`ifdef FETCH_IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ack;
  logic [31:0] instruction;
  logic [31:0] pc_req;
  logic        Inst_Valid;
  logic        Inst_Ack;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wfifo[$];
  iq_entry_t   sb[$];
  logic [31:0] pop_log[$];
  logic [31:0] model_fetch;
  logic [31:0] model_expect;
  bit          ack_en;
  bit          resp_en;
  bit          id_ready_en;
  bit          prev_ack;
  bit          prev_resp;
  logic [31:0] prev_ack_pc;

  fetch_pc_gen #(
    .RESET_PC       (32'hBFC0_0000),
    .IQ_DEPTH       (4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .PC            (PC),
    .Inst_Req_Valid(Inst_Req_Valid),
    .Inst_Req_Ack  (Inst_Req_Ack),
    .instruction   (instruction),
    .pc_req        (pc_req),
    .Inst_Valid    (Inst_Valid),
    .Inst_Ack      (Inst_Ack),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .id_ready      (id_ready)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (pop_log.size() > i) ? pop_log[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: account for the last edge, check state, drive wrapper/ID, check the ID head
  task automatic applyStimulus(input bit redir, input logic [31:0] tgt);
    bit        pending;
    bit        consumed;
    bit        exp_valid;
    iq_entry_t pend_e;
    iq_entry_t head_e;
    @(negedge clk);
    if (prev_resp) void'(wfifo.pop_front());
    if (prev_ack)  wfifo.push_back(prev_ack_pc);

    checkOutput("req_valid", 32'(Inst_Req_Valid),
                32'((wfifo.size() < 2) && (wfifo.size() + sb.size() < 4)));
    checkOutput("pc", PC, model_fetch);
    checkOutput("inst_ack", 32'(Inst_Ack), 32'd1);

    Inst_Req_Ack = ack_en & Inst_Req_Valid;
    prev_ack     = Inst_Req_Ack;
    prev_ack_pc  = PC;
    if (Inst_Req_Ack) model_fetch = model_fetch + 32'd4;

    redirect_valid = redir;
    redirect_pc    = tgt;
    pending        = 1'b0;
    pend_e         = '0;
    if (resp_en && wfifo.size() != 0) begin
      Inst_Valid  = 1'b1;
      pc_req      = wfifo[0];
      instruction = inst_of(wfifo[0]);
      if (!redir && wfifo[0] == model_expect) begin
        pending      = 1'b1;
        pend_e       = '{inst: inst_of(wfifo[0]), pc: wfifo[0]};
        model_expect = model_expect + 32'd4;
      end
    end else begin
      Inst_Valid  = 1'b0;
      pc_req      = 32'h0;
      instruction = 32'h0;
    end
    prev_resp = Inst_Valid;
    if (redir) begin
      model_fetch  = tgt;
      model_expect = tgt;
    end
    id_ready = id_ready_en;

    #1;
    exp_valid = (sb.size() != 0) || (BYP && pending);
    checkOutput("id_valid", 32'(id_valid), 32'(exp_valid));
    consumed = 1'b0;
    if (exp_valid) begin
      head_e = (sb.size() != 0) ? sb[0] : pend_e;
      checkOutput("id_inst", id_inst, head_e.inst);
      checkOutput("id_pc", id_pc, head_e.pc);
      if (id_ready) begin
        pop_log.push_back(head_e.pc);
        if (sb.size() != 0) void'(sb.pop_front());
        else consumed = 1'b1;
      end
    end
    if (pending && !consumed) sb.push_back(pend_e);
    if (redir) sb.delete();
  endtask

  // Directed sequence
  initial begin
    int dup_count;
    reset          = 1'b1;
    Inst_Req_Ack   = 1'b0;
    instruction    = '0;
    pc_req         = '0;
    Inst_Valid     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    model_fetch    = 32'hBFC0_0000;
    model_expect   = 32'hBFC0_0000;
    ack_en = 0; resp_en = 0; id_ready_en = 0;
    prev_ack = 0; prev_resp = 0; prev_ack_pc = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_pc", PC, 32'hBFC0_0000);
    checkOutput("rst_req_valid", 32'(Inst_Req_Valid), 32'd0);
    checkOutput("rst_inst_ack", 32'(Inst_Ack), 32'd0);
    checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
    checkOutput("rst_id_inst", id_inst, 32'd0);
    checkOutput("rst_id_pc", id_pc, 32'd0);
    reset = 1'b0;

    $display("[TB] streaming fetch");
    ack_en = 1; resp_en = 1; id_ready_en = 1;
    repeat (8) applyStimulus(1'b0, 32'h0);
    checkOutput("first_pop", log_at(0), 32'hBFC0_0000);
    checkOutput("second_pop", log_at(1), 32'hBFC0_0004);

    $display("[TB] ID stalled");
    id_ready_en = 0;
    pop_log.delete();
    repeat (12) applyStimulus(1'b0, 32'h0);
    checkOutput("stall_req_valid", 32'(Inst_Req_Valid), 32'd0);
    checkOutput("stall_no_pop", pop_log.size(), 32'd0);
    ack_en = 0; id_ready_en = 1;
    repeat (8) applyStimulus(1'b0, 32'h0);
    checkOutput("stall_drain_count", pop_log.size(), 32'd4);
    checkOutput("stall_drain_order", log_at(3) - log_at(0), 32'd12);

    $display("[TB] redirect with two outstanding");
    ack_en = 1; resp_en = 0;
    repeat (3) applyStimulus(1'b0, 32'h0);
    checkOutput("two_outstanding", wfifo.size(), 32'd2);
    resp_en = 1;
    pop_log.delete();
    applyStimulus(1'b1, 32'h8000_0100);
    repeat (10) applyStimulus(1'b0, 32'h0);
    checkOutput("redir_first_pop", log_at(0), 32'h8000_0100);
    checkOutput("redir_second_pop", log_at(1), 32'h8000_0104);
    ack_en = 0;
    repeat (5) applyStimulus(1'b0, 32'h0);
    checkOutput("redir_drained", wfifo.size(), 32'd0);

    $display("[TB] redirect onto an in-flight address");
    ack_en = 1; resp_en = 1;
    applyStimulus(1'b1, 32'hBFC0_0000);
    repeat (3) applyStimulus(1'b0, 32'h0);
    resp_en = 0;
    pop_log.delete();
    applyStimulus(1'b1, 32'hBFC0_0008);
    resp_en = 1;
    repeat (12) applyStimulus(1'b0, 32'h0);
    dup_count = 0;
    foreach (pop_log[i]) if (pop_log[i] == 32'hBFC0_0008) dup_count++;
    checkOutput("dup_accepted_once", 32'(dup_count), 32'd1);
    checkOutput("dup_next_pop", log_at(2), 32'hBFC0_000C);
    ack_en = 0;
    repeat (5) applyStimulus(1'b0, 32'h0);
    checkOutput("final_drained", wfifo.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
